// File: rtl/stack_arb_pkg.sv
// stack_arb_pkg: shared definitions for the two-requester stack arbiter.
//   state_t         FSM state encoding (IDLE, ISSUE, POPWAIT, RESP)
//   OP_PUSH/OP_POP  encoding of a requester's req_op bit
//   DATA_W_DEF      default data width (matches the stack width)
//   DEPTH_DEF       default stack depth
package stack_arb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 32;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    POPWAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/stack_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin arbiter.
//   req[1:0]   requests
//   last_gnt   index of the requester granted most recently
//   gnt[1:0]   one-hot grant (all zero when nothing is requested)
// When both request, the one not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last_gnt ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: shares one DEPTH x DATA_W hardware stack between two
// requesters. One transaction is in flight at a time; occupancy is tracked
// here so that overflow/underflow never reaches the stack.
//   clk, rst               clock (rising edge), async active-high reset
//   req_valid/op/data      per-requester request (op 0 = push, 1 = pop)
//   gnt                    one-cycle pulse: request accepted
//   rsp_valid/data/err     one-cycle response to the granted requester
//   stk_push/pop/data      strobes and push data to the stack
//   stk_top                stack top-of-stack
//   count                  current occupancy, 0..DEPTH
//   ovf_cnt, udf_cnt       rejected push/pop counters
// Build option: define STACK_ARB_STATS_EN to build the saturating error
// counters; otherwise ovf_cnt/udf_cnt are tied to 0.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid,
  input  logic [1:0]                 req_op,
  input  logic [1:0][DATA_W-1:0]     req_data,
  output logic [1:0]                 gnt,
  output logic [1:0]                 rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err,
  output logic                       stk_push,
  output logic                       stk_pop,
  output logic [DATA_W-1:0]          stk_data,
  input  logic [DATA_W-1:0]          stk_top,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 ovf_cnt,
  output logic [7:0]                 udf_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  state_t            state;
  logic              last_gnt;
  logic              win;
  logic              op_q;
  logic              err_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        arb_gnt;
  logic              full;
  logic              empty;

  assign full  = (count == FULL);
  assign empty = (count == '0);

  rr_arb2 u_rr_arb2 (
    .req      (req_valid),
    .last_gnt (last_gnt),
    .gnt      (arb_gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      win       <= 1'b0;
      op_q      <= OP_PUSH;
      err_q     <= 1'b0;
      data_q    <= '0;
      gnt       <= 2'b00;
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_data  <= '0;
      count     <= '0;
    end else begin
      // Pulsed outputs default low every cycle.
      gnt       <= 2'b00;
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      case (state)
        // Arbitrate and latch the winning transaction.
        IDLE: begin
          if (|req_valid) begin
            gnt      <= arb_gnt;
            win      <= arb_gnt[1];
            last_gnt <= arb_gnt[1];
            op_q     <= req_op[arb_gnt[1]];
            data_q   <= req_data[arb_gnt[1]];
            err_q    <= 1'b0;
            state    <= ISSUE;
          end
        end
        // Strobe the stack, or reject when it would over/underflow.
        ISSUE: begin
          if (op_q == OP_PUSH) begin
            if (!full) begin
              stk_push <= 1'b1;
              stk_data <= data_q;
              count    <= count + 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state <= RESP;
          end else if (!empty) begin
            stk_pop <= 1'b1;
            count   <= count - 1'b1;
            state   <= POPWAIT;
          end else begin
            err_q <= 1'b1;
            state <= RESP;
          end
        end
        // stk_top still shows the popped entry while stk_pop is high.
        POPWAIT: begin
          data_q <= stk_top;
          state  <= RESP;
        end
        // Return the result to the granted requester.
        RESP: begin
          rsp_valid <= win ? 2'b10 : 2'b01;
          rsp_data  <= (err_q || op_q == OP_PUSH) ? '0 : data_q;
          rsp_err   <= err_q;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STACK_ARB_STATS_EN
  logic rej_push;
  logic rej_pop;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign rej_push = (state == ISSUE) && (op_q == OP_PUSH) && full;
  assign rej_pop  = (state == ISSUE) && (op_q == OP_POP) && empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= 8'd0;
      udf_cnt <= 8'd0;
    end else begin
      if (rej_push) ovf_cnt <= sat_inc8(ovf_cnt);
      if (rej_pop)  udf_cnt <= sat_inc8(udf_cnt);
    end
  end
`else
  assign ovf_cnt = 8'd0;
  assign udf_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
`timescale 1ns/1ps
module tb_stack_arbiter;
  import stack_arb_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [1:0]         req_valid = 2'b00;
  logic [1:0]         req_op = 2'b00;
  logic [1:0][DW-1:0] req_data = '0;
  logic [1:0]         gnt, rsp_valid;
  logic [DW-1:0]      rsp_data, stk_data, stk_top;
  logic               rsp_err, stk_push, stk_pop;
  logic [5:0]         count;
  logic [7:0]         ovf_cnt, udf_cnt;

  always #5 clk = ~clk;

  stack_arbiter #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_data(stk_data), .stk_top(stk_top),
    .count(count), .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
  );

  // Environment stack driven by the DUT strobes.
  logic [DW-1:0] mem [DEPTH];
  int sp;
  always @(posedge clk or posedge rst) begin
    if (rst) sp <= 0;
    else if (stk_push && sp < DEPTH) begin
      mem[sp] <= stk_data;
      sp <= sp + 1;
    end else if (stk_pop && sp > 0) sp <= sp - 1;
  end
  assign stk_top = (sp > 0) ? mem[sp-1] : '0;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: a transaction scheduler over a queue-based stack.
  // Each accepted request books its expected outputs into future cycle slots.
  typedef struct {
    logic [1:0]    gnt;
    logic [1:0]    rv;
    logic [DW-1:0] rd;
    logic          re;
    logic          push;
    logic          pop;
    logic [DW-1:0] sd;
    int            dcnt;
    int            dovf;
    int            dudf;
  } slot_t;

  slot_t         ring [8];
  logic [DW-1:0] mq [$];
  int            next_free = 0, m_last = 1;
  int            e_cnt = 0, e_ovf = 0, e_udf = 0;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ring[i] = '{default: '0};
    mq.delete();
    next_free = 0;
    m_last = 1;
    e_cnt = 0;
    e_ovf = 0;
    e_udf = 0;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    int w;
    logic op;
    logic [DW-1:0] d, v;
    cyc++;
    if (rst) model_reset();
    else if (cyc >= next_free && req_valid != 2'b00) begin
      if (req_valid == 2'b11) w = 1 - m_last;
      else w = req_valid[1] ? 1 : 0;
      m_last = w;
      op = req_op[w];
      d = req_data[w];
      ring[cyc % 8].gnt = (w == 1) ? 2'b10 : 2'b01;
      if (op == OP_PUSH) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(d);
          ring[(cyc+1) % 8].push = 1'b1;
          ring[(cyc+1) % 8].sd = d;
          ring[(cyc+1) % 8].dcnt = 1;
        end else begin
          ring[(cyc+1) % 8].dovf = 1;
          ring[(cyc+2) % 8].re = 1'b1;
        end
        ring[(cyc+2) % 8].rv = (w == 1) ? 2'b10 : 2'b01;
        next_free = cyc + 3;
      end else if (mq.size() > 0) begin
        v = mq.pop_back();
        ring[(cyc+1) % 8].pop = 1'b1;
        ring[(cyc+1) % 8].dcnt = -1;
        ring[(cyc+3) % 8].rv = (w == 1) ? 2'b10 : 2'b01;
        ring[(cyc+3) % 8].rd = v;
        next_free = cyc + 4;
      end else begin
        ring[(cyc+1) % 8].dudf = 1;
        ring[(cyc+2) % 8].re = 1'b1;
        ring[(cyc+2) % 8].rv = (w == 1) ? 2'b10 : 2'b01;
        next_free = cyc + 3;
      end
    end
  end

  // Per-cycle comparison plus logs for the directed checks.
  int glog_id [$];
  int glog_cyc [$];
  int rv_seen = 0;

  always @(negedge clk) begin
    slot_t s;
    if (rst) model_reset();
    s = ring[cyc % 8];
    e_cnt += s.dcnt;
    e_ovf += s.dovf;
    e_udf += s.dudf;
    chk("gnt", int'(gnt), int'(s.gnt));
    chk("rsp_valid", int'(rsp_valid), int'(s.rv));
    chk("rsp_data", int'(rsp_data), int'(s.rd));
    chk("rsp_err", int'(rsp_err), int'(s.re));
    chk("stk_push", int'(stk_push), int'(s.push));
    chk("stk_pop", int'(stk_pop), int'(s.pop));
    if (s.push || rst) chk("stk_data", int'(stk_data), int'(s.sd));
    chk("count", int'(count), e_cnt);
`ifdef STACK_ARB_STATS_EN
    chk("ovf_cnt", int'(ovf_cnt), (e_ovf > 255) ? 255 : e_ovf);
    chk("udf_cnt", int'(udf_cnt), (e_udf > 255) ? 255 : e_udf);
`else
    chk("ovf_cnt", int'(ovf_cnt), 0);
    chk("udf_cnt", int'(udf_cnt), 0);
`endif
    ring[cyc % 8] = '{default: '0};
    if (gnt != 2'b00) begin
      glog_id.push_back(gnt[1] ? 1 : 0);
      glog_cyc.push_back(cyc);
    end
    if (rsp_valid != 2'b00) rv_seen++;
  end

  // Drivers: all act 1 ns after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic issue(input int r, input logic op, input logic [DW-1:0] d,
                       output logic [DW-1:0] rd, output logic re, output int lat);
    int g;
    g = -1;
    lat = -1;
    rd = '0;
    re = 1'b0;
    req_op[r] = op;
    req_data[r] = d;
    req_valid[r] = 1'b1;
    for (int i = 0; i < 20 && g < 0; i++) begin
      @(posedge clk); #1;
      if (gnt[r]) g = cyc;
    end
    req_valid[r] = 1'b0;
    if (g < 0) begin
      chk("gnt_timeout", 0, 1);
      return;
    end
    for (int i = 0; i < 10 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (rsp_valid[r]) begin
        lat = cyc - g;
        rd = rsp_data;
        re = rsp_err;
      end
    end
    if (lat < 0) chk("rsp_timeout", 0, 1);
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic re;
    int lat, ng, snap;
    int exp_id [6] = '{0, 1, 0, 1, 0, 1};

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_count", int'(count), 0);
    chk("reset_gnt", int'(gnt), 0);

    // Push from requester 0, pop from requester 1.
    issue(0, OP_PUSH, 16'hA5A5, rd, re, lat);
    chk("t1_push_lat", lat, 2);
    chk("t1_push_err", int'(re), 0);
    chk("t1_push_count", int'(count), 1);
    issue(1, OP_POP, 16'h0000, rd, re, lat);
    chk("t1_pop_data", int'(rd), 16'hA5A5);
    chk("t1_pop_lat", lat, 3);
    chk("t1_pop_count", int'(count), 0);

    // Both requesters continuously pushing.
    glog_id.delete();
    glog_cyc.delete();
    req_op = 2'b00;
    req_data[0] = 16'h1000;
    req_data[1] = 16'h2000;
    req_valid = 2'b11;
    ng = 0;
    for (int i = 0; i < 40 && ng < 6; i++) begin
      @(posedge clk); #1;
      if (gnt != 2'b00) begin
        ng++;
        if (gnt[0]) req_data[0] = req_data[0] + 16'd1;
        else req_data[1] = req_data[1] + 16'd1;
      end
    end
    req_valid = 2'b00;
    repeat (3) @(posedge clk); #1;
    chk("t2_grants", glog_id.size(), 6);
    for (int i = 0; i < 6 && i < glog_id.size(); i++) begin
      chk("t2_gnt_order", glog_id[i], exp_id[i]);
      if (i > 0) chk("t2_gnt_spacing", glog_cyc[i] - glog_cyc[i-1], 3);
    end
    chk("t2_count", int'(count), 6);

    // Pop on empty.
    do_reset();
    issue(1, OP_POP, 16'h0000, rd, re, lat);
    chk("t3_err", int'(re), 1);
    chk("t3_data", int'(rd), 0);
    chk("t3_lat", lat, 2);
    chk("t3_count", int'(count), 0);
`ifdef STACK_ARB_STATS_EN
    chk("t3_udf", int'(udf_cnt), 1);
`else
    chk("t3_udf", int'(udf_cnt), 0);
`endif

    // Fill to DEPTH, then one more.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      issue(i % 2, OP_PUSH, DW'(16'h0100 + i), rd, re, lat);
      if (re) chk("t4_push_ok", int'(re), 0);
    end
    chk("t4_full_count", int'(count), 32);
    issue(0, OP_PUSH, 16'hDEAD, rd, re, lat);
    chk("t4_ovf_err", int'(re), 1);
    chk("t4_ovf_lat", lat, 2);
    chk("t4_ovf_count", int'(count), 32);
`ifdef STACK_ARB_STATS_EN
    chk("t4_ovf_cnt", int'(ovf_cnt), 1);
`else
    chk("t4_ovf_cnt", int'(ovf_cnt), 0);
`endif

    // LIFO order and pop latency.
    do_reset();
    for (int i = 1; i <= 3; i++) issue(0, OP_PUSH, DW'(i), rd, re, lat);
    for (int i = 3; i >= 1; i--) begin
      issue(1, OP_POP, 16'h0000, rd, re, lat);
      chk("t5_pop_data", int'(rd), i);
      chk("t5_pop_lat", lat, 3);
    end

    // Reset during POPWAIT.
    do_reset();
    issue(1, OP_PUSH, 16'h0055, rd, re, lat);
    req_op[1] = OP_POP;
    req_valid[1] = 1'b1;
    ng = 0;
    for (int i = 0; i < 20 && ng == 0; i++) begin
      @(posedge clk); #1;
      if (gnt[1]) ng = 1;
    end
    req_valid[1] = 1'b0;
    chk("t6_pop_gnt", ng, 1);
    @(posedge clk); #1;
    snap = rv_seen;
    rst = 1'b1;
    #1;
    chk("t6_rst_count", int'(count), 0);
    chk("t6_rst_pop", int'(stk_pop), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("t6_no_rsp", rv_seen - snap, 0);
    req_op = 2'b00;
    req_data[0] = 16'h0A0A;
    req_data[1] = 16'h0B0B;
    req_valid = 2'b11;
    ng = 0;
    for (int i = 0; i < 20 && ng == 0; i++) begin
      @(posedge clk); #1;
      if (gnt != 2'b00) begin
        ng = 1;
        chk("t6_first_gnt", int'(gnt), 1);
      end
    end
    req_valid = 2'b00;
    if (ng == 0) chk("t6_gnt_timeout", 0, 1);
    repeat (4) @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
